cmp_seq_flags: RTL and testbench

Parametrised, multi-cycle compare unit that computes `a - b` as `a + ~b + 1`, CHUNK bits per cycle, LSB first. It latches the resulting N, Z, C and V flags into a flag register. It also evaluates a 4-bit ARM-style condition code against those stored flags. It sits beside the single-cycle ALU and serves wide operands and the conditional-execution logic without a full-width carry chain.

---
 rtl/cmp_seq_flags.sv | 146 ++++++++++++++
 tb/tb_cmp_seq_flags.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_flags.sv
// Multi-cycle compare: a - b computed as a + ~b + 1, CHUNK bits per cycle, LSB first.
// Latches {n,z,c,v} at the end of the sweep and evaluates an ARM condition code on them.
module cmp_seq_flags #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cond,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags,
  output logic             cond_true
);

  localparam int K = WIDTH / CHUNK;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             carry_q;
  logic             zacc_q;

  logic [CHUNK:0]   sum_d;
  logic             zchunk_d;
  logic [3:0]       flags_d;

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = c & !z;
      4'd9:    cond_eval = !c | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Current chunk always sits in the low bits of the operand shift registers.
  always_comb begin
    sum_d    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, ~b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    zchunk_d = (sum_d[CHUNK-1:0] == '0);
    flags_d  = {sum_d[CHUNK-1],
                zacc_q & zchunk_d,
                sum_d[CHUNK],
                (a_msb_q ^ b_msb_q) & (a_msb_q ^ sum_d[CHUNK-1])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            flags_q <= flags_d;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Operand/accumulator datapath: loaded on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      a_q     <= a;
      b_q     <= b;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
      carry_q <= 1'b1;
      zacc_q  <= 1'b1;
    end else if (state_q == S_RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      carry_q <= sum_d[CHUNK];
      zacc_q  <= zacc_q & zchunk_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign flags     = flags_q;
  assign cond_true = cond_eval(cond, flags_q);

endmodule

// File: tb/tb_cmp_seq_flags.sv
// Bench for cmp_seq_flags: directed and random compares on a 32/8 instance plus a
// 16-bit sweep over CHUNK = 16, 4 and 1, all checked against an arithmetic reference.
module tb_cmp_seq_flags;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [3:0]  cond32 = '0;
  logic        busy32, done32, ct32;
  logic [3:0]  flags32;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic [3:0]  cond16 = '0;
  logic [2:0]  busy16, done16, ct16;
  logic [3:0]  flags16 [3];

  int tests = 0;
  int fails = 0;
  int K16 [3] = '{1, 4, 16};

  always #5 clk = ~clk;

  cmp_seq_flags #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cond(cond32),
    .busy(busy32), .done(done32), .flags(flags32), .cond_true(ct32));

  cmp_seq_flags #(.WIDTH(16), .CHUNK(16)) u16_k1 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cond(cond16),
    .busy(busy16[0]), .done(done16[0]), .flags(flags16[0]), .cond_true(ct16[0]));

  cmp_seq_flags #(.WIDTH(16), .CHUNK(4)) u16_k4 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cond(cond16),
    .busy(busy16[1]), .done(done16[1]), .flags(flags16[1]), .cond_true(ct16[1]));

  cmp_seq_flags #(.WIDTH(16), .CHUNK(1)) u16_k16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cond(cond16),
    .busy(busy16[2]), .done(done16[2]), .flags(flags16[2]), .cond_true(ct16[2]));

  // Reference flags from whole-number arithmetic on w-bit operands.
  function automatic logic [3:0] ref_flags(input int w, input logic [31:0] av, input logic [31:0] bv);
    longint one, half, full, ua, ub, r, sa, sb, d;
    logic n, z, c, v;
    one  = 1;
    half = one << (w - 1);
    full = one << w;
    ua   = longint'(av) & (full - 1);
    ub   = longint'(bv) & (full - 1);
    r    = (ua - ub) & (full - 1);
    n    = (r >= half);
    z    = (ua == ub);
    c    = (ua >= ub);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    d    = sa - sb;
    v    = (d >= half) || (d < -half);
    return {n, z, c, v};
  endfunction

  function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle32();
    int n;
    n = 0;
    while (busy32 !== 1'b0 && n < 50) begin
      realign();
      n++;
    end
    chk("idle32_timeout", busy32, 0);
  endtask

  task automatic wait_idle16();
    int n;
    n = 0;
    while (busy16 !== 3'b000 && n < 50) begin
      realign();
      n++;
    end
    chk("idle16_timeout", busy16, 0);
  endtask

  task automatic cc32(input logic [3:0] c, input logic exp);
    cond32 = c;
    #1;
    chk($sformatf("cond32_%0d", c), ct32, exp);
  endtask

  task automatic all_cond32(input logic [3:0] f);
    for (int c = 0; c < 16; c++) begin
      cond32 = 4'(c);
      #1;
      chk($sformatf("cond32_model_%0d", c), ct32, model_cond(4'(c), f));
    end
    realign();
  endtask

  task automatic run32(input logic [31:0] av, input logic [31:0] bv, input bit scramble,
                       output logic [3:0] fexp);
    int lat;
    wait_idle32();
    start32 = 1'b1;
    a32 = av;
    b32 = bv;
    realign();
    start32 = 1'b0;
    if (scramble) begin a32 = $urandom; b32 = $urandom; end
    lat = 1;
    while (done32 !== 1'b1 && lat < 40) begin
      realign();
      if (scramble) begin a32 = $urandom; b32 = $urandom; end
      lat++;
    end
    chk("lat32", lat, 5);
    fexp = ref_flags(32, av, bv);
    chk("flags32", flags32, fexp);
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv);
    int lat [3];
    logic [3:0] fexp;
    wait_idle16();
    start16 = 1'b1;
    a16 = av;
    b16 = bv;
    realign();
    start16 = 1'b0;
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 20; cyc++) begin
      for (int j = 0; j < 3; j++)
        if (done16[j] === 1'b1 && lat[j] == 0) lat[j] = cyc;
      realign();
    end
    fexp = ref_flags(16, {16'b0, av}, {16'b0, bv});
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("lat16_k%0d", K16[j]), lat[j], K16[j] + 1);
      chk($sformatf("flags16_k%0d", K16[j]), flags16[j], fexp);
    end
    for (int c = 0; c < 16; c++) begin
      cond16 = 4'(c);
      #1;
      for (int j = 0; j < 3; j++)
        chk($sformatf("cond16_k%0d_%0d", K16[j], c), ct16[j], model_cond(4'(c), fexp));
    end
    realign();
  endtask

  initial begin
    logic [3:0] f;
    int dq [$];
    int cnt;

    // Reset for two cycles.
    rst = 1'b1;
    realign();
    realign();
    rst = 1'b0;
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_flags", flags32, 4'b0000);
    cc32(4'd0, 1'b0);
    cc32(4'd1, 1'b1);
    realign();

    // Equal operands.
    run32(32'h0000_0005, 32'h0000_0005, 1'b0, f);
    chk("eq_flags_lit", flags32, 4'b0110 << 0 | 4'b0000 | 4'b0010 | 4'b0100);
    cc32(4'd0, 1'b1);
    cc32(4'd1, 1'b0);
    cc32(4'd8, 1'b0);
    cc32(4'd9, 1'b1);
    realign();

    // Less-than.
    run32(32'd3, 32'd5, 1'b0, f);
    chk("lt_flags_lit", flags32, 4'b1000);
    cc32(4'd11, 1'b1);
    cc32(4'd3, 1'b1);
    cc32(4'd10, 1'b0);
    realign();

    // Signed overflow.
    run32(32'h8000_0000, 32'd1, 1'b0, f);
    chk("ovf_flags_lit", flags32, 4'b0011);
    cc32(4'd11, 1'b1);
    cc32(4'd8, 1'b1);
    realign();

    // Upper-chunk zero detection.
    run32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, f);
    chk("up_flags_lit", flags32, 4'b1001);
    run32(32'h0100_0000, 32'h0000_0000, 1'b0, f);
    chk("zchunk_flags_lit", flags32, 4'b0010);
    all_cond32(f);

    // Operands changed during RUN are ignored.
    run32(32'd10, 32'd3, 1'b1, f);
    chk("scramble_flags_lit", flags32, 4'b0010);

    // Start held high: a done pulse every K+2 cycles.
    wait_idle32();
    start32 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      realign();
      if (done32 === 1'b1) dq.push_back(i);
    end
    start32 = 1'b0;
    chk("hold_pulses", dq.size(), 5);
    if (dq.size() >= 3) begin
      chk("hold_gap1", dq[1] - dq[0], 6);
      chk("hold_gap2", dq[2] - dq[1], 6);
    end

    // Reset in the third RUN cycle.
    run32(32'd3, 32'd5, 1'b0, f);
    wait_idle32();
    start32 = 1'b1;
    a32 = 32'd7;
    b32 = 32'd2;
    realign();
    start32 = 1'b0;
    realign();
    realign();
    rst = 1'b1;
    realign();
    rst = 1'b0;
    chk("midrst_busy", busy32, 0);
    chk("midrst_flags", flags32, 4'b0000);
    chk("midrst_done", done32, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      realign();
      if (done32 !== 1'b0) cnt++;
    end
    chk("midrst_no_done", cnt, 0);

    // Reset and start together: reset wins.
    rst = 1'b1;
    start32 = 1'b1;
    realign();
    rst = 1'b0;
    start32 = 1'b0;
    chk("rst_start_busy", busy32, 0);
    realign();
    chk("rst_start_busy2", busy32, 0);

    // Random 32-bit compares.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i == 2) ? ra : $urandom;
      if (i == 4) rb = {ra[31:8], 8'($urandom)};
      run32(ra, rb, 1'b0, f);
      all_cond32(f);
    end

    // 16-bit parameter sweep.
    run16(16'h1234, 16'h1234);
    run16(16'h8000, 16'h0001);
    run16(16'h0001, 16'hFFFF);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (i == 5) ? ra : 16'($urandom);
      run16(ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
